rdid_uart_reporter: RTL and testbench
=====================================

Name: rdid_uart_reporter

Overview:
Downstream consumer of the SPI flash RDID master. It detects the end of an RDID transaction, which is the rising edge of the master's chip_select. It then captures the 24-bit JEDEC ID (manufacturer, memory type, capacity) and transmits it as 8-character ASCII hex text over a UART TX line (8N1, LSB first), so the ID can be read on a host terminal. It sits between the SPI master's ID outputs and the board UART pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
chip_select  input  1  chip_select from the SPI master; rising edge marks transaction complete
manufacture_id  input  8  ID byte 0 from the SPI master
memory_type  input  8  ID byte 1 from the SPI master
memory_capacity  input  8  ID byte 2 from the SPI master
uart_tx  output  1  serial output; idle high
busy  output  1  high while a message is being captured or sent
done  output  1  one-cycle pulse after the last stop bit of a message
dropped  output  1  one-cycle pulse when a trigger arrives while busy

Behaviour:
- Reset: one clock, clk. reset is asynchronous and active-high. While reset is high: uart_tx=1, busy=0, done=0, dropped=0, state=IDLE, cs_q=1, char index=0, baud counter=0.
- cs_q resets to 1 so that a master idling with chip_select high after reset produces no spurious trigger.
- Edge detect: cs_q <= chip_select each clk. trigger = chip_select & ~cs_q.
- FSM states: IDLE, CAPTURE, LOAD_CHAR, START_BIT, DATA_BITS, STOP_BIT, FINISH.
- IDLE: on trigger, go to CAPTURE and set busy=1.
- CAPTURE: one cycle after the trigger, load id_reg[23:0] = {manufacture_id, memory_type, memory_capacity}. This extra cycle lets the master's final MISO sample settle. Clear char index to 0, then go to LOAD_CHAR.
- LOAD_CHAR: select the character for the current index.
  - Index 0..5 gives nibble id_reg[23-4*idx -: 4].
  - ASCII conversion: nibble 0-9 gives 8'h30+n; nibble A-F gives 8'h37+n (uppercase).
  - Index 6 gives 8'h0D; index 7 gives 8'h0A.
  - Load the shift register, then go to START_BIT.
- START_BIT: uart_tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA_BITS.
- DATA_BITS: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles, then go to STOP_BIT.
- STOP_BIT: uart_tx=1 for CLKS_PER_BIT cycles.
  - If index < 7: increment index and go to LOAD_CHAR.
  - Else: go to FINISH.
- LOAD_CHAR takes zero line time. The next start bit begins on the clk immediately after the previous stop bit's last cycle, so characters are back-to-back.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Baud counter: loaded with CLKS_PER_BIT-1 at the start of each bit and decremented to 0. Width is clog2(CLKS_PER_BIT).
- Frame length: 80*CLKS_PER_BIT cycles from the first start bit to the end of the last stop bit.
- uart_tx is registered and is 1 in every state except START_BIT and DATA_BITS.
- Trigger while not IDLE: ignored, and dropped pulses for 1 cycle. The message in flight and id_reg are unaffected.
- ID inputs changing after CAPTURE have no effect on the message.
- Reset mid-message: uart_tx returns to 1 immediately (asynchronously). The message is aborted with no done pulse, and no partial retransmission occurs after release.
- chip_select held constant at any level produces no message.

Decomposition:
- Shared package rdid_pkg holds:
  - the FSM state encoding constants;
  - the ASCII constants ASCII_0=8'h30, ASCII_A_OFS=8'h37, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - MSG_LEN=8.
- One natural sub-module: uart_tx_byte. It is an 8N1 byte serialiser parameterised by CLKS_PER_BIT, with ports start, data[7:0], tx, busy, done. The START_BIT/DATA_BITS/STOP_BIT sequencing lives there.
- The top level keeps edge detect, capture, the hex/char mux, the char index and the message FSM.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
1. Reset asserted, chip_select=1 -> uart_tx=1, busy=0, done=0, dropped=0; no activity for 500 cycles after release.
2. IDs 0x20/0xBA/0x18, chip_select 1->0 for 100 cycles ->1 -> bytes 0x32,0x30,0x42,0x41,0x31,0x38,0x0D,0x0A decoded. Each bit is exactly 4 cycles, the message lasts 320 cycles, and done is a single pulse.
3. Hex boundaries: IDs 0x09/0xAF/0xF0 -> "09AFF0\r\n", i.e. 0x30,0x39,0x41,0x46,0x46,0x30,0x0D,0x0A.
4. Second chip_select rising edge at cycle 100 of a message, with IDs changed to 0xFF after capture -> dropped pulses once and the original message is unchanged.
5. reset pulsed during DATA_BITS of char 3 -> uart_tx=1 in the same cycle and no done. The next trigger sends a complete, correct message.
6. Two triggers separated by 400 cycles -> two complete messages, two done pulses, dropped never asserted.

Source files
------------

// File: rtl/rdid_pkg.sv
// rdid_pkg
// Shared definitions for the RDID UART reporter:
//   - message FSM and byte-serialiser state encodings
//   - ASCII constants used to render the JEDEC ID as hex text
//   - message length (6 hex digits + CR + LF)
//   - helper that turns a nibble into an uppercase ASCII hex digit
package rdid_pkg;

  // Message-level FSM owned by the top level
  typedef enum logic [2:0] {
    MSG_IDLE,
    MSG_CAPTURE,
    MSG_LOAD_CHAR,
    MSG_SEND,
    MSG_FINISH
  } msg_state_t;

  // Bit-level FSM owned by the byte serialiser
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START_BIT,
    TX_DATA_BITS,
    TX_STOP_BIT
  } tx_state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h37;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int         MSG_LEN       = 8;
  localparam logic [2:0] LAST_CHAR_IDX = 3'(MSG_LEN - 1);

  // 0-9 map onto '0'..'9'; 10-15 map onto 'A'..'F' (0x37 + 10 = 0x41 = 'A')
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return ASCII_0 + {4'b0000, nibble};
    end else begin
      return ASCII_A_OFS + {4'b0000, nibble};
    end
  endfunction

endpackage

// File: rtl/rdid_uart_reporter_uart_tx_byte.sv
// uart_tx_byte
// 8N1 byte serialiser, LSB first, each bit held CLKS_PER_BIT clocks.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   start       - request to send data; accepted only while busy is low
//   data[7:0]   - byte to send, sampled when start is accepted
//   tx          - registered serial line, idle high
//   busy        - line is committed beyond the current cycle; low while idle
//                 and also during the final stop-bit cycle, so a new byte can
//                 be accepted there and its start bit follows with no gap
//   done        - one-cycle pulse one clock before the final stop-bit cycle,
//                 giving the producer a cycle to present the next byte
module uart_tx_byte
  import rdid_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  tx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic last_cycle;
  logic accept;

  assign last_cycle = (cnt_q == '0);
  assign busy       = (state_q != TX_IDLE) && !((state_q == TX_STOP_BIT) && last_cycle);
  assign accept     = start && !busy;
  // With CLKS_PER_BIT >= 2 the stop bit always has a cnt==1 cycle to flag
  assign done       = (state_q == TX_STOP_BIT) && (cnt_q == CNT_ONE);
  assign tx         = tx_q;

  // Bit sequencer: each bit reloads the baud counter and counts it down to 0.
  // A start accepted in the last stop-bit cycle chains straight into the next
  // start bit, so consecutive bytes are back-to-back on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else if (accept) begin
      state_q <= TX_START_BIT;
      cnt_q   <= CNT_RELOAD;
      bit_q   <= '0;
      shift_q <= data;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
        end
        TX_START_BIT: begin
          if (last_cycle) begin
            state_q <= TX_DATA_BITS;
            cnt_q   <= CNT_RELOAD;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        TX_DATA_BITS: begin
          if (last_cycle) begin
            cnt_q <= CNT_RELOAD;
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP_BIT;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        TX_STOP_BIT: begin
          if (last_cycle) begin
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/rdid_uart_reporter.sv
// rdid_uart_reporter
// Watches the SPI RDID master's chip_select; on its rising edge captures the
// 24-bit JEDEC ID and prints it on the UART as "MMTTCC\r\n" (uppercase hex).
// Ports:
//   clk, reset           - system clock, asynchronous active-high reset
//   chip_select          - from the SPI master; rising edge ends a transaction
//   manufacture_id[7:0]  - ID byte 0
//   memory_type[7:0]     - ID byte 1
//   memory_capacity[7:0] - ID byte 2
//   uart_tx              - registered serial output, idle high
//   busy                 - high from the trigger until the message is finished
//   done                 - one-cycle pulse after the last stop bit
//   dropped              - one-cycle pulse for a trigger that arrived while busy
module rdid_uart_reporter
  import rdid_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_select,
  input  logic [7:0] manufacture_id,
  input  logic [7:0] memory_type,
  input  logic [7:0] memory_capacity,
  output logic       uart_tx,
  output logic       busy,
  output logic       done,
  output logic       dropped
);

  msg_state_t  state_q;
  logic        cs_q;
  logic [23:0] id_q;
  logic [2:0]  idx_q;
  logic        busy_q;
  logic        done_q;
  logic        dropped_q;

  logic       trigger;
  logic [7:0] char_sel;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_line;

  // cs_q resets high so a master idling with chip_select high is not a trigger
  assign trigger = chip_select & ~cs_q;

  // Character for the current index: six hex digits, most significant first,
  // followed by CR LF
  always_comb begin
    char_sel = ASCII_LF;
    case (idx_q)
      3'd0:    char_sel = hex_to_ascii(id_q[23:20]);
      3'd1:    char_sel = hex_to_ascii(id_q[19:16]);
      3'd2:    char_sel = hex_to_ascii(id_q[15:12]);
      3'd3:    char_sel = hex_to_ascii(id_q[11:8]);
      3'd4:    char_sel = hex_to_ascii(id_q[7:4]);
      3'd5:    char_sel = hex_to_ascii(id_q[3:0]);
      3'd6:    char_sel = ASCII_CR;
      default: char_sel = ASCII_LF;
    endcase
  end

  assign tx_start = (state_q == MSG_LOAD_CHAR) && !tx_busy;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (char_sel),
    .tx    (tx_line),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  // Message FSM. The serialiser's done arrives one cycle before its last stop
  // cycle, so LOAD_CHAR (or FINISH) lines up with that last cycle and the next
  // start bit, or the done pulse, follows immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MSG_IDLE;
      cs_q      <= 1'b1;
      id_q      <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      cs_q      <= chip_select;
      done_q    <= 1'b0;
      dropped_q <= trigger && (state_q != MSG_IDLE);
      case (state_q)
        MSG_IDLE: begin
          if (trigger) begin
            state_q <= MSG_CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        MSG_CAPTURE: begin
          // One cycle after the edge so the master's last MISO sample settles
          id_q    <= {manufacture_id, memory_type, memory_capacity};
          idx_q   <= '0;
          state_q <= MSG_LOAD_CHAR;
        end
        MSG_LOAD_CHAR: begin
          if (!tx_busy) begin
            state_q <= MSG_SEND;
          end
        end
        MSG_SEND: begin
          if (tx_done) begin
            if (idx_q == LAST_CHAR_IDX) begin
              state_q <= MSG_FINISH;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= MSG_LOAD_CHAR;
            end
          end
        end
        MSG_FINISH: begin
          if (!tx_busy) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= MSG_IDLE;
          end
        end
        default: begin
          state_q <= MSG_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx = tx_line;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_rdid_uart_reporter.sv
// tb_rdid_uart_reporter
// Directed bench for rdid_uart_reporter with CLKS_PER_BIT = 4. A UART
// receiver task decodes the line bit by bit and the decoded text is compared
// against hand-written ASCII for each ID.
module tb_rdid_uart_reporter;

  localparam int CPB = 4;

  // Expected messages, first character in the top byte
  localparam logic [63:0] MSG_20BA18 = {8'h32, 8'h30, 8'h42, 8'h41, 8'h31, 8'h38, 8'h0D, 8'h0A};
  localparam logic [63:0] MSG_09AFF0 = {8'h30, 8'h39, 8'h41, 8'h46, 8'h46, 8'h30, 8'h0D, 8'h0A};
  localparam logic [63:0] MSG_A501C3 = {8'h41, 8'h35, 8'h30, 8'h31, 8'h43, 8'h33, 8'h0D, 8'h0A};
  localparam logic [63:0] MSG_120000 = {8'h31, 8'h32, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
  localparam logic [63:0] MSG_7F3ED4 = {8'h37, 8'h46, 8'h33, 8'h45, 8'h44, 8'h34, 8'h0D, 8'h0A};
  localparam logic [63:0] MSG_012345 = {8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
  localparam logic [63:0] MSG_EFCDAB = {8'h45, 8'h46, 8'h43, 8'h44, 8'h41, 8'h42, 8'h0D, 8'h0A};

  logic       clk;
  logic       reset;
  logic       chip_select;
  logic [7:0] manufacture_id;
  logic [7:0] memory_type;
  logic [7:0] memory_capacity;
  logic       uart_tx;
  logic       busy;
  logic       done;
  logic       dropped;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cyc           = 0;
  int txLowCount    = 0;
  int doneCount     = 0;
  int droppedCount  = 0;

  rdid_uart_reporter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .chip_select     (chip_select),
    .manufacture_id  (manufacture_id),
    .memory_type     (memory_type),
    .memory_capacity (memory_capacity),
    .uart_tx         (uart_tx),
    .busy            (busy),
    .done            (done),
    .dropped         (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running cycle count and event counters, sampled at the rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (uart_tx === 1'b0) txLowCount = txLowCount + 1;
    if (done === 1'b1) doneCount = doneCount + 1;
    if (dropped === 1'b1) droppedCount = droppedCount + 1;
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present an ID and pulse chip_select low; the trigger is the return to high
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] t, input logic [7:0] c,
                               input int lowCycles);
    int snap;
    @(negedge clk);
    manufacture_id  = m;
    memory_type     = t;
    memory_capacity = c;
    chip_select     = 1'b0;
    snap            = txLowCount;
    repeat (lowCycles) @(negedge clk);
    checkOutput("no tx while cs low", txLowCount - snap, 0);
    chip_select = 1'b1;
  endtask

  // Decode one 8N1 character; every one of the CPB samples of a bit must agree
  task automatic receiveByte(output logic [7:0] b, output int gap, output bit ok,
                             output bit timedOut, output int startCyc);
    logic first;
    b        = '0;
    gap      = 0;
    ok       = 1'b1;
    timedOut = 1'b0;
    startCyc = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0) begin
      gap++;
      if (gap > 2000) begin
        timedOut = 1'b1;
        return;
      end
      @(negedge clk);
    end
    startCyc = cyc;
    for (int s = 1; s < CPB; s++) begin
      @(negedge clk);
      if (uart_tx !== 1'b0) ok = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      first = uart_tx;
      b[k]  = first;
      for (int s = 1; s < CPB; s++) begin
        @(negedge clk);
        if (uart_tx !== first) ok = 1'b0;
      end
    end
    for (int s = 0; s < CPB; s++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
  endtask

  // Receive a full message, then check the frame length and the done pulse
  task automatic receiveMessage(input logic [63:0] expMsg, input string tag);
    logic [7:0] b;
    int gap;
    bit ok;
    bit timedOut;
    int sc;
    int firstCyc;
    firstCyc = 0;
    for (int i = 0; i < 8; i++) begin
      receiveByte(b, gap, ok, timedOut, sc);
      checkOutput($sformatf("%s char%0d timeout", tag, i), timedOut, 1'b0);
      if (timedOut) return;
      if (i == 0) firstCyc = sc;
      checkOutput($sformatf("%s char%0d value", tag, i), b, expMsg[63-8*i -: 8]);
      checkOutput($sformatf("%s char%0d bit timing", tag, i), ok, 1'b1);
      if (i > 0) checkOutput($sformatf("%s char%0d gap", tag, i), gap, 0);
    end
    checkOutput($sformatf("%s frame cycles", tag), cyc - firstCyc + 1, 80 * CPB);
    @(negedge clk);
    checkOutput($sformatf("%s done after stop", tag), done, 1'b1);
    checkOutput($sformatf("%s busy after stop", tag), busy, 1'b0);
    @(negedge clk);
    checkOutput($sformatf("%s done one cycle", tag), done, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int gap;
    bit ok;
    bit timedOut;
    int sc;
    int dc;
    int dr;
    int tl;
    int t1;

    reset           = 1'b1;
    chip_select     = 1'b1;
    manufacture_id  = '0;
    memory_type     = '0;
    memory_capacity = '0;

    // Reset with chip_select high, then a long quiet period
    repeat (3) @(negedge clk);
    checkOutput("reset uart_tx", uart_tx, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset dropped", dropped, 1'b0);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    checkOutput("quiet tx low", txLowCount, 0);
    checkOutput("quiet done", doneCount, 0);
    checkOutput("quiet dropped", droppedCount, 0);
    checkOutput("quiet busy", busy, 1'b0);

    // Basic message
    $display("[TB] message 20/BA/18");
    dc = doneCount;
    dr = droppedCount;
    applyStimulus(8'h20, 8'hBA, 8'h18, 100);
    receiveMessage(MSG_20BA18, "id20BA18");
    @(negedge clk);
    checkOutput("id20BA18 done pulses", doneCount - dc, 1);
    checkOutput("id20BA18 dropped", droppedCount - dr, 0);

    // Hex digit boundaries 9/A and F/0
    $display("[TB] message 09/AF/F0");
    applyStimulus(8'h09, 8'hAF, 8'hF0, 20);
    receiveMessage(MSG_09AFF0, "id09AFF0");

    // Second trigger mid-message with IDs changed after capture
    $display("[TB] trigger while busy");
    dc = doneCount;
    dr = droppedCount;
    applyStimulus(8'hA5, 8'h01, 8'hC3, 20);
    fork
      receiveMessage(MSG_A501C3, "dropTrig");
      begin
        repeat (5) @(negedge clk);
        manufacture_id  = 8'hFF;
        memory_type     = 8'hFF;
        memory_capacity = 8'hFF;
        repeat (85) @(negedge clk);
        chip_select = 1'b0;
        repeat (10) @(negedge clk);
        chip_select = 1'b1;
      end
    join
    @(negedge clk);
    checkOutput("dropTrig dropped pulses", droppedCount - dr, 1);
    checkOutput("dropTrig done pulses", doneCount - dc, 1);

    // Reset during the data bits of character 3 ('0' = 0x30, bit0 is 0)
    $display("[TB] reset mid-message");
    dc = doneCount;
    applyStimulus(8'h12, 8'h00, 8'h00, 20);
    for (int i = 0; i < 3; i++) begin
      receiveByte(b, gap, ok, timedOut, sc);
      checkOutput($sformatf("rstMid char%0d", i), b, MSG_120000[63-8*i -: 8]);
    end
    @(negedge clk);
    checkOutput("rstMid char3 start bit", uart_tx, 1'b0);
    repeat (CPB - 1) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("rstMid data bit0 low", uart_tx, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("rstMid async uart_tx", uart_tx, 1'b1);
    checkOutput("rstMid async busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    tl = txLowCount;
    repeat (300) @(negedge clk);
    checkOutput("rstMid no retransmit", txLowCount - tl, 0);
    checkOutput("rstMid no done", doneCount - dc, 0);
    checkOutput("rstMid busy after release", busy, 1'b0);
    applyStimulus(8'h7F, 8'h3E, 8'hD4, 20);
    receiveMessage(MSG_7F3ED4, "afterRst");

    // Two triggers about 400 cycles apart
    $display("[TB] two messages");
    dc = doneCount;
    dr = droppedCount;
    applyStimulus(8'h01, 8'h23, 8'h45, 10);
    t1 = cyc;
    receiveMessage(MSG_012345, "pairA");
    while (cyc < t1 + 390) @(negedge clk);
    applyStimulus(8'hEF, 8'hCD, 8'hAB, 10);
    receiveMessage(MSG_EFCDAB, "pairB");
    @(negedge clk);
    checkOutput("pair done pulses", doneCount - dc, 2);
    checkOutput("pair dropped", droppedCount - dr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
